alu_result_stage: RTL and testbench

//  Execute stage directly downstream of the B-operand shifter. It accepts operand A and the shifted B

---
 rtl/alu_result_stage.sv | 145 ++++++++++++++
 tb/tb_alu_result_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// ALU result stage: computes ADD/SUB/AND/NOT-B on (ain, bin), latches flags into a
// {V,N,Z} status register and queues results in a 2-entry elastic buffer (valid/ready).
module alu_result_stage #(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] ain,
  input  logic [W-1:0] bin,
  input  logic [1:0]   aluop,
  input  logic         loads,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c_out,
  output logic [2:0]   status
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_NOTB = 2'b11;

  if (DEPTH != 2) begin : g_depth_check
    $error("alu_result_stage only supports DEPTH == 2");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   head_q, head_d;
  logic [W-1:0]   tail_q, tail_d;
  logic [2:0]     status_q, status_d;

  logic           accept;
  logic           pop;
  logic [W-1:0]   b_eff;
  logic [W-1:0]   sum;
  logic [W-1:0]   alu_res;
  logic           flag_z;
  logic           flag_n;
  logic           flag_v;

  // Arithmetic: SUB reuses the adder as ain + ~bin + 1.
  always_comb begin
    b_eff = (aluop == OP_SUB) ? ~bin : bin;
    sum   = ain + b_eff + {{(W-1){1'b0}}, (aluop == OP_SUB)};
  end

  always_comb begin
    alu_res = '0;
    flag_v  = 1'b0;
    case (aluop)
      OP_ADD: begin
        alu_res = sum;
        flag_v  = (ain[W-1] == bin[W-1]) && (sum[W-1] != ain[W-1]);
      end
      OP_SUB: begin
        alu_res = sum;
        flag_v  = (ain[W-1] != bin[W-1]) && (sum[W-1] != ain[W-1]);
      end
      OP_AND: begin
        alu_res = ain & bin;
      end
      OP_NOTB: begin
        alu_res = ~bin;
      end
      default: begin
        alu_res = '0;
      end
    endcase
    flag_z = (alu_res == '0);
    flag_n = alu_res[W-1];
  end

  // Ready/valid are decoded from the state register only.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d  = alu_res;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && pop) begin
          head_d = alu_res;
        end else if (accept) begin
          tail_d  = alu_res;
          state_d = ST_TWO;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  always_comb begin
    status_d = status_q;
    if (accept && loads) begin
      status_d = {flag_v, flag_n, flag_z};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      status_q <= 3'b000;
    end else begin
      state_q  <= state_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      status_q <= status_d;
    end
  end

  assign c_out  = head_q;
  assign status = status_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and randomized checks for alu_result_stage against hand values and a queue model.
module tb_alu_result_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ain;
  logic [15:0] bin;
  logic [1:0]  aluop;
  logic        loads;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] c_out;
  logic [2:0]  status;

  int total = 0;
  int bad   = 0;

  alu_result_stage #(.W(16), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .bin       (bin),
    .aluop     (aluop),
    .loads     (loads),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c_out     (c_out),
    .status    (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op, input logic ld, input logic ordy);
    in_valid  = v;
    ain       = a;
    bin       = b;
    aluop     = op;
    loads     = ld;
    out_ready = ordy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU using wide signed arithmetic for overflow detection.
  task automatic alu_model(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                           output logic [15:0] res, output logic [2:0] flags);
    int sa, sb, sr;
    logic v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    v  = 1'b0;
    case (op)
      2'b00: begin sr = sa + sb; res = 16'(sr); v = (sr > 32767) || (sr < -32768); end
      2'b01: begin sr = sa - sb; res = 16'(sr); v = (sr > 32767) || (sr < -32768); end
      2'b10: res = a & b;
      default: res = ~b;
    endcase
    flags = {v, res[15], (res == 16'h0000)};
  endtask

  logic [15:0] q[$];
  logic [15:0] m_res;
  logic [2:0]  m_flags;
  logic [2:0]  m_status;
  logic        stalled;
  logic [15:0] stalled_val;
  int          pushed;
  int          popped;
  int          ncyc;
  logic        acc;
  logic        pp;

  initial begin
    drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0);
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;

    // 1: fill both entries, then reset while an op is still being offered
    drive(1'b1, 16'h0001, 16'h0002, 2'b00, 1'b1, 1'b0);
    cyc();
    cyc();
    check("fill_in_ready", in_ready, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_status", status, 3'b000);
    check("rst_c_out", c_out, 16'h0000);
    $display("txn reset-with-full-buffer: out_valid=%0b in_ready=%0b status=%b c_out=%h",
             out_valid, in_ready, status, c_out);

    // 2: basic ADD then SUB with pop every cycle
    drive(1'b1, 16'd3, 16'd5, 2'b00, 1'b1, 1'b1);
    cyc();
    check("add_c_out", c_out, 16'd8);
    check("add_valid", out_valid, 1);
    check("add_status", status, 3'b000);
    $display("txn ADD 3+5: c_out=%h status=%b", c_out, status);
    drive(1'b1, 16'd5, 16'd5, 2'b01, 1'b1, 1'b1);
    cyc();
    check("sub_c_out", c_out, 16'd0);
    check("sub_status", status, 3'b001);
    $display("txn SUB 5-5: c_out=%h status=%b", c_out, status);

    // 5: loads=0 keeps status while the result still flows
    drive(1'b1, 16'd3, 16'd4, 2'b00, 1'b0, 1'b1);
    cyc();
    check("noload_c_out", c_out, 16'd7);
    check("noload_status", status, 3'b001);
    $display("txn ADD 3+4 loads=0: c_out=%h status=%b", c_out, status);

    // 3: signed overflow corners
    drive(1'b1, 16'h7FFF, 16'h0001, 2'b00, 1'b1, 1'b1);
    cyc();
    check("ovf_add_c_out", c_out, 16'h8000);
    check("ovf_add_status", status, 3'b110);
    $display("txn ADD 7FFF+1: c_out=%h status=%b", c_out, status);
    drive(1'b1, 16'h8000, 16'h0001, 2'b01, 1'b1, 1'b1);
    cyc();
    check("ovf_sub_c_out", c_out, 16'h7FFF);
    check("ovf_sub_status", status, 3'b100);
    $display("txn SUB 8000-1: c_out=%h status=%b", c_out, status);
    drive(1'b1, 16'hFFFF, 16'h0001, 2'b00, 1'b1, 1'b1);
    cyc();
    check("wrap_c_out", c_out, 16'h0000);
    check("wrap_status", status, 3'b001);
    $display("txn ADD FFFF+1: c_out=%h status=%b", c_out, status);
    drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
    cyc();
    check("drain_valid", out_valid, 0);

    // 4: back-pressure, third op must wait, then drain in order
    drive(1'b1, 16'hF0F0, 16'hFF00, 2'b10, 1'b0, 1'b0);
    cyc();
    check("bp1_in_ready", in_ready, 1);
    check("bp1_c_out", c_out, 16'hF000);
    drive(1'b1, 16'h1234, 16'h00FF, 2'b11, 1'b0, 1'b0);
    cyc();
    check("bp2_in_ready", in_ready, 0);
    check("bp2_c_out", c_out, 16'hF000);
    drive(1'b1, 16'h0001, 16'h0001, 2'b00, 1'b0, 1'b0);
    cyc();
    check("bp3_in_ready", in_ready, 0);
    check("bp3_c_out_hold", c_out, 16'hF000);
    $display("txn back-pressure: in_ready=%0b c_out=%h", in_ready, c_out);
    out_ready = 1'b1;
    cyc();
    check("emit2", c_out, 16'hFF00);
    check("emit2_in_ready", in_ready, 1);
    cyc();
    check("emit3", c_out, 16'h0002);
    $display("txn drain: head=%h", c_out);
    in_valid = 1'b0;
    cyc();
    check("emit_done_valid", out_valid, 0);

    // 6: random traffic against a queue model
    m_status = status;
    q.delete();
    stalled = 1'b0;
    stalled_val = '0;
    pushed = 0;
    popped = 0;
    ncyc = 0;
    while ((pushed < 10000 || q.size() != 0) && ncyc < 60000) begin
      drive((pushed < 10000) && ($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      check("rnd_out_valid", out_valid, (q.size() != 0));
      check("rnd_in_ready", in_ready, (q.size() < 2));
      if (stalled) begin
        check("rnd_stall_valid", out_valid, 1);
        check("rnd_stall_c_out", c_out, stalled_val);
      end
      acc = in_valid & (q.size() < 2);
      pp  = (q.size() != 0) & out_ready;
      if (pp) begin
        check("rnd_order", c_out, q[0]);
        void'(q.pop_front());
        popped++;
      end
      if (acc) begin
        alu_model(ain, bin, aluop, m_res, m_flags);
        q.push_back(m_res);
        if (loads) m_status = m_flags;
        pushed++;
      end
      stalled     = out_valid & ~out_ready;
      stalled_val = c_out;
      cyc();
      ncyc++;
      check("rnd_status", status, m_status);
    end
    check("rnd_budget", (ncyc < 60000), 1);
    check("rnd_popped", popped, 10000);
    $display("txn random: pushed=%0d popped=%0d cycles=%0d", pushed, popped, ncyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
